act_mem_sequencer: RTL and testbench
====================================

# act_mem_sequencer

Command-driven read sequencer for the activation memory wrapper. It accepts a read command (precision mode, word count) over a valid/ready handshake and drives the wrapper's `addr` and `precision_mode` inputs through one bank sweep per word. It delay-matches the wrapper latency so downstream consumers receive `rd_valid`/last flags aligned with `data_out`. It sits between the layer controller and the activation memory wrapper.

## Interface
- `PMAX`, 8, max precision (bits)
- `PMIN`, 2, min precision (bits)
- `NUM_BANKS`, PMAX/PMIN, banks behind the wrapper
- `ADDR_WIDTH`, $clog2(NUM_BANKS), wrapper address width
- `PMODE_WIDTH`, $clog2(NUM_BANKS), precision-mode width
- `COUNT_WIDTH`, 16, width of word count
- `MEM_LATENCY`, 1, cycles from `mem_addr` to valid wrapper `data_out` (≥1)

Ports:
- `clk`  in  1  clock, all logic on rising edge
- `reset`  in  1  asynchronous, active-low reset
- `cmd_valid`  in  1  command present
- `cmd_ready`  out  1  sequencer can accept a command
- `cmd_pmode`  in  PMODE_WIDTH  precision mode for the command
- `cmd_num_words`  in  COUNT_WIDTH  words to read
- `stall`  in  1  suspend issue of new beats
- `mem_precision_mode`  out  PMODE_WIDTH  to wrapper `precision_mode`
- `mem_addr`  out  ADDR_WIDTH  to wrapper `addr`
- `rd_valid`  out  1  wrapper `data_out` valid this cycle
- `rd_last_beat`  out  1  qualifies `rd_valid`: last beat of a word
- `rd_last_word`  out  1  qualifies `rd_valid`: beat belongs to last word
- `busy`  out  1  command in progress (ISSUE or DRAIN)
- `done`  out  1  one-cycle pulse at command completion

## Operation
- Beats per word `B = 1 << min(pmode, ADDR_WIDTH)`; `pmode` latched at acceptance.
- FSM states: IDLE, ISSUE, DRAIN.
- IDLE: `cmd_ready=1`. On `cmd_valid`, latch `pmode` and word count.
  - Count 0: pulse `done` the next cycle and stay in IDLE.
  - Count >0: go to ISSUE with beat counter = 0 and word counter = 0.
- ISSUE: each cycle with `stall=0`, issue one beat: `mem_addr = beat counter`, then increment the beat counter.
  - Beat counter wraps at B-1 and increments the word counter.
  - Issue of the last beat of the last word moves to DRAIN.
  - With `stall=1`: no issue, counters hold, `mem_addr` holds, and in-flight beats still emerge.
- DRAIN: wait until the valid pipeline is empty, then pulse `done` and return to IDLE.
- `cmd_ready=0` in ISSUE and DRAIN. A command is never accepted in the `done` cycle's predecessor state; it can be accepted in the same cycle `done` is asserted (state is IDLE).
- `mem_precision_mode` holds the latched `pmode` from acceptance until the next acceptance.
- `rd_valid`, `rd_last_beat` and `rd_last_word` are issue-cycle flags delayed exactly MEM_LATENCY cycles.
- Word counter is COUNT_WIDTH bits. Max count is 2^COUNT_WIDTH−1, with no overflow.

## Timing
- Reset values: `cmd_ready=1`, `mem_addr=0`, `mem_precision_mode=0`, `rd_valid=0`, `rd_last_beat=0`, `rd_last_word=0`, `busy=0`, `done=0`, state IDLE.
- Handshake accepted at edge T. First `mem_addr` is valid from T+1.
- `rd_valid` for the beat issued in cycle t asserts in cycle t+MEM_LATENCY.
- Without stall, W words take W·B issue cycles. `done` asserts the cycle after the last `rd_valid`.
- `busy` is 1 from T+1 through the last DRAIN cycle, and 0 in the `done` cycle.
- Reset asserted mid-command: immediate return to reset values. The pipeline is flushed, and no `done` or `rd_valid` is produced for the aborted command.

## Structure
- Shared package `act_mem_pkg`: FSM state enum and the `beats_per_word(pmode)` function.
- One sub-module `act_mem_valid_pipe`: MEM_LATENCY-deep shift register of {valid, last_beat, last_word}, with async active-low clear. It also exposes an `empty` flag for DRAIN.
- All registers are reset asynchronously on `reset` low.

## Test plan
- pmode=0, words=3, MEM_LATENCY=1:
  - `mem_addr` = 0 in three consecutive cycles.
  - `rd_valid` on 3 cycles, each with `rd_last_beat=1`; `rd_last_word` only on the third.
  - `done` one cycle after that.
- pmode=2, words=2:
  - `mem_addr` sequence 0,1,2,3,0,1,2,3.
  - `rd_last_beat` on the 4th and 8th `rd_valid`.
  - `busy` high for 8+MEM_LATENCY cycles.
- pmode=3 (clipped), words=1: same four-beat 0..3 sweep as pmode=2. `mem_precision_mode` reads 3 throughout.
- words=0: `done` pulses one cycle after acceptance. No `rd_valid`, `busy` stays 0.
- pmode=1, words=2, `stall` high for 3 cycles after the second beat:
  - `mem_addr` holds 1.
  - Exactly 4 `rd_valid` total, in order 0,1,0,1.
  - `done` delayed by 3 cycles.
- Reset low during the 3rd beat of a pmode=2 command:
  - All outputs are at reset values within the same cycle.
  - A new command after reset runs cleanly from `mem_addr=0`.

Source files
------------

// File: rtl/act_mem_pkg.sv
// act_mem_sequencer shared types: widths, FSM states,
// read-flag bundle and the beats-per-word helper.
package act_mem_pkg;

  localparam int PMAX        = 8;
  localparam int PMIN        = 2;
  localparam int NUM_BANKS   = PMAX / PMIN;
  localparam int ADDR_WIDTH  = $clog2(NUM_BANKS);
  localparam int PMODE_WIDTH = $clog2(NUM_BANKS);
  localparam int COUNT_WIDTH = 16;

  typedef logic [ADDR_WIDTH-1:0]  addr_t;
  typedef logic [ADDR_WIDTH:0]    beats_t;
  typedef logic [PMODE_WIDTH-1:0] pmode_t;
  typedef logic [COUNT_WIDTH-1:0] count_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DRAIN
  } state_t;

  typedef struct packed {
    logic valid;
    logic last_beat;
    logic last_word;
  } rd_flags_t;

  // Modes beyond the bank count clip to a full sweep.
  function automatic beats_t beats_per_word(input pmode_t pmode);
    if (int'(pmode) >= ADDR_WIDTH)
      return beats_t'(1) << ADDR_WIDTH;
    return beats_t'(1) << pmode;
  endfunction

endpackage

// File: rtl/act_mem_sequencer_if.sv
// Command / wrapper / read-flag bundle of act_mem_sequencer.
// master: layer controller side; slave: the sequencer.
interface act_mem_sequencer_if;
  import act_mem_pkg::*;

  logic   cmd_valid;
  logic   cmd_ready;
  pmode_t cmd_pmode;
  count_t cmd_num_words;
  logic   stall;
  pmode_t mem_precision_mode;
  addr_t  mem_addr;
  logic   rd_valid;
  logic   rd_last_beat;
  logic   rd_last_word;
  logic   busy;
  logic   done;

  modport master (
    output cmd_valid, cmd_pmode,
    output cmd_num_words, stall,
    input  cmd_ready, mem_precision_mode,
    input  mem_addr, rd_valid,
    input  rd_last_beat, rd_last_word,
    input  busy, done
  );

  modport slave (
    input  cmd_valid, cmd_pmode,
    input  cmd_num_words, stall,
    output cmd_ready, mem_precision_mode,
    output mem_addr, rd_valid,
    output rd_last_beat, rd_last_word,
    output busy, done
  );

endinterface

// File: rtl/act_mem_sequencer_valid_pipe.sv
// act_mem_valid_pipe: DEPTH-stage delay of the read flags.
// Ports: clk, rst_n (async low clear), i_flags, o_flags, o_empty.
module act_mem_valid_pipe
  import act_mem_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic      clk,
  input  logic      rst_n,
  input  rd_flags_t i_flags,
  output rd_flags_t o_flags,
  output logic      o_empty
);

  rd_flags_t r_stage [DEPTH];
  logic      w_inflight;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++)
        r_stage[i] <= '0;
    end else begin
      r_stage[0] <= i_flags;
      for (int i = 1; i < DEPTH; i++)
        r_stage[i] <= r_stage[i-1];
    end
  end

  // Empty means nothing is left behind the output
  // stage once this edge shifts: the beat now at the
  // output is the final one.
  always_comb begin
    w_inflight = i_flags.valid;
    for (int i = 0; i < DEPTH - 1; i++)
      w_inflight = w_inflight | r_stage[i].valid;
  end

  assign o_flags = r_stage[DEPTH-1];
  assign o_empty = !w_inflight;

endmodule

// File: rtl/act_mem_sequencer.sv
// act_mem_sequencer: command-driven bank-sweep read sequencer.
// Ports: clk, reset (async low), bus (slave: cmd, mem, rd, status).
module act_mem_sequencer
  import act_mem_pkg::*;
#(
  parameter int MEM_LATENCY = 1
) (
  input logic              clk,
  input logic              reset,
  act_mem_sequencer_if.slave bus
);

  state_t    r_state;
  pmode_t    r_pmode;
  count_t    r_num_words;
  count_t    r_word;
  addr_t     r_beat;
  addr_t     r_mem_addr;
  logic      r_cmd_ready;
  logic      r_busy;
  logic      r_done;

  beats_t    w_bpw;
  logic      w_issue;
  logic      w_last_beat;
  logic      w_last_word;
  logic      w_empty;
  rd_flags_t w_flags_in;
  rd_flags_t w_flags_out;

  assign w_bpw       = beats_per_word(r_pmode);
  assign w_last_beat = beats_t'(r_beat) == w_bpw - beats_t'(1);
  assign w_last_word = r_word == r_num_words - count_t'(1);
  assign w_issue     = (r_state == ST_ISSUE) && !bus.stall;

  assign w_flags_in = {w_issue,
                       w_issue & w_last_beat,
                       w_issue & w_last_word};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_pmode     <= '0;
      r_num_words <= '0;
      r_word      <= '0;
      r_beat      <= '0;
      r_mem_addr  <= '0;
      r_cmd_ready <= 1'b1;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (bus.cmd_valid) begin
            r_pmode     <= bus.cmd_pmode;
            r_num_words <= bus.cmd_num_words;
            r_word      <= '0;
            r_beat      <= '0;
            r_mem_addr  <= '0;
            if (bus.cmd_num_words == '0) begin
              r_done <= 1'b1;
            end else begin
              r_state     <= ST_ISSUE;
              r_cmd_ready <= 1'b0;
              r_busy      <= 1'b1;
            end
          end
        end
        ST_ISSUE: begin
          if (w_issue) begin
            r_mem_addr <= r_beat;
            if (w_last_beat) begin
              r_beat <= '0;
              r_word <= r_word + count_t'(1);
              if (w_last_word)
                r_state <= ST_DRAIN;
            end else begin
              r_beat <= r_beat + addr_t'(1);
            end
          end
        end
        ST_DRAIN: begin
          if (w_empty) begin
            r_state     <= ST_IDLE;
            r_cmd_ready <= 1'b1;
            r_busy      <= 1'b0;
            r_done      <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  act_mem_valid_pipe #(
    .DEPTH (MEM_LATENCY)
  ) u_pipe (
    .clk     (clk),
    .rst_n   (reset),
    .i_flags (w_flags_in),
    .o_flags (w_flags_out),
    .o_empty (w_empty)
  );

  // The live beat counter drives the bank address while
  // issuing; a stalled cycle keeps the last issued one.
  assign bus.mem_addr = w_issue ? r_beat : r_mem_addr;

  assign bus.cmd_ready          = r_cmd_ready;
  assign bus.mem_precision_mode = r_pmode;
  assign bus.rd_valid           = w_flags_out.valid;
  assign bus.rd_last_beat       = w_flags_out.last_beat;
  assign bus.rd_last_word       = w_flags_out.last_word;
  assign bus.busy               = r_busy;
  assign bus.done               = r_done;

endmodule

// File: tb/tb_act_mem_sequencer.sv
// tb_act_mem_sequencer: directed commands with a beat
// scoreboard for act_mem_sequencer.
module tb_act_mem_sequencer;
  import act_mem_pkg::*;

  localparam int L = 1;

  typedef struct {
    int addr;
    bit lb;
    bit lw;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;

  act_mem_sequencer_if bus ();

  act_mem_sequencer #(
    .MEM_LATENCY (L)
  ) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   n_busy = 0;
  int   n_done = 0;
  int   n_rd = 0;
  int   done_cyc = 0;
  int   last_rd_cyc = 0;
  int   prev_addr = 0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  function automatic int bpw(input int pm);
    return 1 << ((pm > 2) ? 2 : pm);
  endfunction

  // Runs at the falling edge: counts events and retires
  // one scoreboard beat per rd_valid. The address is the
  // one driven MEM_LATENCY (=1) cycle earlier.
  task automatic mon();
    exp_t e;
    cyc++;
    if (bus.busy === 1'b1) n_busy++;
    if (bus.done === 1'b1) begin
      n_done++;
      done_cyc = cyc;
    end
    if (bus.rd_valid === 1'b1) begin
      n_rd++;
      last_rd_cyc = cyc;
      chk("rd_expected", sb.size() > 0, 1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("rd_addr", prev_addr, e.addr);
        chk("rd_last_beat", bus.rd_last_beat, e.lb);
        chk("rd_last_word", bus.rd_last_word, e.lw);
      end
    end
    prev_addr = int'(bus.mem_addr);
  endtask

  task automatic step();
    @(negedge clk);
    mon();
    @(posedge clk);
    #1;
  endtask

  task automatic push_cmd(input int pm, input int nw);
    exp_t e;
    int bt;
    bt = bpw(pm);
    bus.cmd_valid     = 1'b1;
    bus.cmd_pmode     = pmode_t'(pm);
    bus.cmd_num_words = count_t'(nw);
    for (int w = 0; w < nw; w++)
      for (int b = 0; b < bt; b++) begin
        e.addr = b;
        e.lb   = (b == bt - 1);
        e.lw   = (w == nw - 1);
        sb.push_back(e);
      end
  endtask

  task automatic chk_rst();
    chk("rst_cmd_ready", bus.cmd_ready, 1);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_pmode", bus.mem_precision_mode, 0);
    chk("rst_rd_valid", bus.rd_valid, 0);
    chk("rst_last_beat", bus.rd_last_beat, 0);
    chk("rst_last_word", bus.rd_last_word, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
  endtask

  task automatic run_cmd(input int pm, input int nw,
                         input int st_from,
                         input int st_len);
    int a, d0, r0, b0, bt, hold;
    bit seen;
    bt   = bpw(pm);
    hold = (st_from > 0) ? (st_from - 1) % bt : 0;
    chk("cmd_ready_idle", bus.cmd_ready, 1);
    push_cmd(pm, nw);
    d0 = n_done;
    r0 = n_rd;
    b0 = n_busy;
    step();
    a = cyc;
    bus.cmd_valid = 1'b0;
    seen = 1'b0;
    for (int k = 1; k <= 200 && !seen; k++) begin
      bus.stall = (k > st_from) && (k <= st_from + st_len);
      @(negedge clk);
      mon();
      chk("pmode_hold", bus.mem_precision_mode, pm);
      if (bus.stall)
        chk("stall_addr_hold", bus.mem_addr, hold);
      if (bus.done === 1'b1) begin
        seen = 1'b1;
        chk("busy_in_done", bus.busy, 0);
        chk("ready_in_done", bus.cmd_ready, 1);
      end
      @(posedge clk);
      #1;
    end
    bus.stall = 1'b0;
    chk("done_seen", seen, 1);
    chk("done_latency", done_cyc - a,
        (nw == 0) ? 1 : nw * bt + st_len + L + 1);
    chk("rd_count", n_rd - r0, nw * bt);
    chk("busy_cycles", n_busy - b0,
        (nw == 0) ? 0 : nw * bt + st_len + L);
    chk("done_count", n_done - d0, 1);
    chk("sb_drained", sb.size(), 0);
    if (nw > 0)
      chk("done_after_rd", done_cyc - last_rd_cyc, 1);
  endtask

  initial begin
    int d0, r0;
    rst_n             = 1'b0;
    bus.cmd_valid     = 1'b0;
    bus.cmd_pmode     = '0;
    bus.cmd_num_words = '0;
    bus.stall         = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    mon();
    chk_rst();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();

    run_cmd(0, 3, 0, 0);
    run_cmd(2, 2, 0, 0);
    run_cmd(3, 1, 0, 0);
    run_cmd(1, 0, 0, 0);
    run_cmd(1, 2, 2, 3);

    // Abort a pmode=2 command while its third beat issues.
    push_cmd(2, 2);
    step();
    bus.cmd_valid = 1'b0;
    step();
    step();
    rst_n = 1'b0;
    @(negedge clk);
    mon();
    chk_rst();
    sb.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    d0 = n_done;
    r0 = n_rd;
    repeat (4) step();
    chk("abort_no_done", n_done - d0, 0);
    chk("abort_no_rd", n_rd - r0, 0);
    run_cmd(2, 1, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

endmodule
